serial_shifter: RTL and testbench
=================================

SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; power of two, >= 8.
REQ-002 Parameter STEP, default 4, maximum bits shifted per cycle; power of two, 1 <= STEP <= WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_val  input  WIDTH  operand.
REQ-008 in_sham  input  $clog2(WIDTH)  shift amount.
REQ-009 in_op  input  shift_op_e (3 bits)  SLL, SRL, SRA, ROL, ROR.
REQ-010 kill  input  1  abort any in-flight operation (pipeline flush).
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out_data  output  WIDTH  result.

Function
REQ-014 States: IDLE, SHIFT, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-015 Accept: in_valid && in_ready at an edge latches in_val into the data register, in_sham into the remaining counter, and in_op; next state SHIFT if in_sham != 0, else DONE.
REQ-016 SHIFT: each edge applies shift of k = min(remaining, STEP) bits per the latched op; remaining -= k; next state DONE when remaining <= STEP, else SHIFT.
REQ-017 Latency: out_valid first high ceil(in_sham/STEP)+1 cycles after the accept cycle for in_sham > 0; 1 cycle after for in_sham = 0.
REQ-018 Result semantics: SLL zero-fill left; SRL zero-fill right; SRA sign-fill right from operand MSB; ROL/ROR rotate modulo WIDTH; equal to a single-cycle shift by in_sham.
REQ-019 SRA sign is the original operand MSB and stays correct across all steps.
REQ-020 DONE: out_data held stable while out_valid && !out_ready; out_valid && out_ready at an edge -> IDLE.
REQ-021 No back-to-back overlap: a new request is accepted only in IDLE; inputs ignored otherwise.
REQ-022 kill high at an edge in SHIFT or DONE -> IDLE next cycle; no out_valid for the aborted op.
REQ-023 kill has priority over out_ready handshake and over accept; kill && in_valid in IDLE accepts nothing.
REQ-024 out_data in IDLE/SHIFT undefined for consumers; implementation drives the data register.
REQ-025 Shift amounts use only $clog2(WIDTH) bits; no wrap of remaining below zero.

Reset
REQ-026 rst high at an edge: state = IDLE, remaining = 0, data register = 0, latched op = SLL.
REQ-027 Outputs during/after reset: in_ready = 1, out_valid = 0, out_data = 0.
REQ-028 rst mid-SHIFT or mid-DONE discards the operation; rst has priority over kill and all handshakes.

Structure
REQ-029 Package shift_pkg holds shift_op_e enum (SLL=0, SRL=1, SRA=2, ROL=3, ROR=4) and state enum.
REQ-030 One combinational sub-module shift_stage (val, amount 0..STEP, op, sign -> out) performs one step; serial_shifter instantiates it once.
REQ-031 No multiplier or full barrel shifter; per-step logic sized to STEP.

Verification (WIDTH=32, STEP=4)
REQ-032 SLL 0x0000_0001 sham=31 -> 0x8000_0000, out_valid 9 cycles after accept.
REQ-033 SRA 0x8000_0000 sham=4 -> 0xF800_0000 after 2 cycles; SRA 0x8000_0000 sham=31 -> 0xFFFF_FFFF.
REQ-034 ROR 0x0000_00F1 sham=4 -> 0x1000_000F; ROL 0x8000_0001 sham=1 -> 0x0000_0003.
REQ-035 SRL 0xDEAD_BEEF sham=0 -> 0xDEAD_BEEF, out_valid 1 cycle after accept.
REQ-036 Hold out_ready low 3 cycles in DONE -> out_data stable, in_ready low; new in_valid ignored until handshake.
REQ-037 kill in 3rd SHIFT cycle of sham=20 -> IDLE next cycle, no out_valid; rst mid-SHIFT -> REQ-027 outputs next cycle.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the serial shifter: operation codes and controller states.
package shift_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned STATE_W = 2;

    typedef enum logic [OP_W-1:0] {
        SLL = 3'd0,
        SRL = 3'd1,
        SRA = 3'd2,
        ROL = 3'd3,
        ROR = 3'd4
    } shift_op_e;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

endpackage : shift_pkg

// File: rtl/shift_stage.sv
// One combinational step of the serial shifter: shifts val by 0..STEP bits.
// Ports:
//   val    - current partial result
//   amount - bits to shift this step (0..STEP)
//   op     - shift operation
//   sign   - fill bit for SRA (the original operand MSB)
//   out    - shifted value
// Each candidate uses a constant shift distance, so the logic is a
// (STEP+1)-way mux of wiring, not a full barrel shifter.
module shift_stage
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic [WIDTH-1:0]           val,
    input  logic [$clog2(STEP+1)-1:0]  amount,
    input  shift_op_e                  op,
    input  logic                       sign,
    output logic [WIDTH-1:0]           out
);

    localparam int unsigned AMT_W = $clog2(STEP + 1);

    // Select the constant-distance candidate matching amount.
    always_comb begin
        out = val;
        for (int unsigned k = 0; k <= STEP; k++) begin
            if (amount == AMT_W'(k)) begin
                case (op)
                    SLL:     out = val << k;
                    SRL:     out = val >> k;
                    // Fill from the latched sign, not val's MSB, which has
                    // already been overwritten by earlier steps.
                    SRA:     out = WIDTH'({{WIDTH{sign}}, val} >> k);
                    ROL:     out = WIDTH'(({val, val} << k) >> WIDTH);
                    ROR:     out = WIDTH'({val, val} >> k);
                    default: out = val;
                endcase
            end
        end
    end

endmodule : shift_stage

// File: rtl/serial_shifter.sv
// Multi-cycle shifter: applies up to STEP bits of shift per cycle until the
// requested amount is consumed, then presents the result with valid/ready.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - request handshake (ready only in IDLE)
//   in_val/in_sham/in_op - operand, shift amount, operation
//   kill                 - abort any in-flight operation
//   out_valid/out_ready  - result handshake (valid only in DONE)
//   out_data             - result (data register)
module serial_shifter
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_val,
    input  logic [$clog2(WIDTH)-1:0]   in_sham,
    input  shift_op_e                  in_op,
    input  logic                       kill,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data
);

    localparam int unsigned SHAM_W = $clog2(WIDTH);
    localparam int unsigned AMT_W  = $clog2(STEP + 1);

    shift_state_e       state_q,     state_d;
    logic [SHAM_W-1:0]  rem_q,       rem_d;
    logic [WIDTH-1:0]   data_q,      data_d;
    shift_op_e          op_q,        op_d;
    logic               sign_q,      sign_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [AMT_W-1:0]   step_c;
    logic [WIDTH-1:0]   stage_out_c;

    // Bits to shift this cycle: min(remaining, STEP).
    always_comb begin
        if (32'(rem_q) > STEP) begin
            step_c = AMT_W'(STEP);
        end else begin
            step_c = AMT_W'(rem_q);
        end
    end

    shift_stage #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_stage (
        .val    (data_q),
        .amount (step_c),
        .op     (op_q),
        .sign   (sign_q),
        .out    (stage_out_c)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        data_d  = data_q;
        op_d    = op_q;
        sign_d  = sign_q;

        case (state_q)
            IDLE: begin
                // kill also blocks acceptance in IDLE.
                if (in_valid && !kill) begin
                    data_d  = in_val;
                    rem_d   = in_sham;
                    op_d    = in_op;
                    sign_d  = in_val[WIDTH-1];
                    state_d = (in_sham != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    data_d  = stage_out_c;
                    rem_d   = rem_q - SHAM_W'(step_c);
                    state_d = (32'(rem_q) <= STEP) ? DONE : SHIFT;
                end
            end
            DONE: begin
                if (kill || out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            data_q      <= '0;
            op_q        <= SLL;
            sign_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;

endmodule : serial_shifter

// File: tb/tb_serial_shifter.sv
// Self-checking bench for serial_shifter (WIDTH=32, STEP=4).
module tb_serial_shifter;
    import shift_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_val;
    logic [4:0]  in_sham;
    shift_op_e   in_op;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] sb_q[$];

    serial_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_val    (in_val),
        .in_sham   (in_sham),
        .in_op     (in_op),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: single-cycle shift by the full amount.
    function automatic logic [31:0] model(input logic [31:0] v, input logic [4:0] s,
                                          input shift_op_e op);
        int sh;
        sh = int'(s);
        case (op)
            SLL: return v << sh;
            SRL: return v >> sh;
            SRA: return 32'($signed(v) >>> sh);
            ROL: return (sh == 0) ? v : ((v << sh) | (v >> (32 - sh)));
            ROR: return (sh == 0) ? v : ((v >> sh) | (v << (32 - sh)));
            default: return v;
        endcase
    endfunction

    // Issue one op, check latency, data (via scoreboard) and handshake.
    // hold = cycles out_ready stays low once out_valid rises.
    task automatic run_op(input logic [31:0] v, input logic [4:0] s, input shift_op_e op,
                          input int hold, input string name);
        int lat;
        int exp_lat;
        int guard;
        logic [31:0] exp_d;
        logic [31:0] first_d;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        n_checks++;
        if (!in_ready) begin
            n_fail++;
            $display("FAIL %s ready_timeout: in_ready=%b required 1", name, in_ready);
            return;
        end
        in_valid = 1'b1;
        in_val   = v;
        in_sham  = s;
        in_op    = op;
        sb_q.push_back(model(v, s, op));
        exp_lat  = (s == 0) ? 1 : ((int'(s) + 3) / 4) + 1;
        tick();
        in_valid = 1'b0;
        in_val   = $urandom;
        in_sham  = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        n_checks++;
        if (!out_valid) begin
            n_fail++;
            $display("FAIL %s valid_timeout: out_valid=%b required 1", name, out_valid);
            void'(sb_q.pop_front());
            return;
        end
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        exp_d = sb_q.pop_front();
        n_checks++;
        if (out_data !== exp_d) begin
            n_fail++;
            $display("FAIL %s data: got %h required %h", name, out_data, exp_d);
        end
        first_d = out_data;
        for (int i = 0; i < hold; i++) begin
            // A competing request during backpressure must be ignored.
            in_valid = 1'b1;
            in_val   = $urandom;
            in_sham  = 5'd7;
            in_op    = SLL;
            tick();
            n_checks++;
            if (out_data !== first_d || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL %s hold%0d: data=%h rdy=%b vld=%b required data=%h rdy=0 vld=1",
                         name, i, out_data, in_ready, out_valid, first_d);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s handshake: rdy=%b vld=%b required rdy=1 vld=0",
                     name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_during: rdy=%b vld=%b data=%h required 1 0 0",
                     in_ready, out_valid, out_data);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_after: rdy=%b vld=%b data=%h required 1 0 0",
                     in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_directed();
        run_op(32'h0000_0001, 5'd31, SLL, 0, "sll31");
        run_op(32'h8000_0000, 5'd4,  SRA, 0, "sra4");
        run_op(32'h8000_0000, 5'd31, SRA, 0, "sra31");
        run_op(32'h0000_00F1, 5'd4,  ROR, 0, "ror4");
        run_op(32'h8000_0001, 5'd1,  ROL, 0, "rol1");
        run_op(32'hDEAD_BEEF, 5'd0,  SRL, 0, "srl0");
        run_op(32'h1234_5678, 5'd5,  SRL, 0, "srl5");
        run_op(32'hF000_000F, 5'd8,  ROL, 0, "rol8");
    endtask

    task automatic test_backpressure();
        run_op(32'hA5A5_0F0F, 5'd13, ROR, 3, "hold3");
    endtask

    task automatic test_kill();
        int seen;
        // kill with in_valid in IDLE: nothing accepted
        kill     = 1'b1;
        in_valid = 1'b1;
        in_val   = 32'h1;
        in_sham  = 5'd3;
        in_op    = SLL;
        tick();
        kill     = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_idle: rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
        end
        // kill in third SHIFT cycle of a 20-bit shift
        in_valid = 1'b1;
        in_val   = 32'hCAFE_F00D;
        in_sham  = 5'd20;
        in_op    = SRL;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_shift: rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL kill_no_valid: out_valid cycles=%0d required 0", seen);
        end
        // kill while DONE with out_ready low
        in_valid = 1'b1;
        in_val   = 32'h5;
        in_sham  = 5'd0;
        in_op    = SLL;
        tick();
        in_valid = 1'b0;
        kill     = 1'b1;
        tick();
        kill     = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL kill_done: rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
        end
    endtask

    task automatic test_rst_mid();
        in_valid = 1'b1;
        in_val   = 32'h7777_1111;
        in_sham  = 5'd31;
        in_op    = ROL;
        tick();
        in_valid = 1'b0;
        tick();
        rst  = 1'b1;
        kill = 1'b1;
        tick();
        rst  = 1'b0;
        kill = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid: rdy=%b vld=%b data=%h required 1 0 0",
                     in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        logic [4:0]  s;
        shift_op_e   op;
        for (int i = 0; i < 30; i++) begin
            v  = $urandom;
            s  = 5'($urandom_range(0, 31));
            op = shift_op_e'(3'($urandom_range(0, 4)));
            run_op(v, s, op, $urandom_range(0, 2), $sformatf("b2b%0d", i));
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_val    = '0;
        in_sham   = '0;
        in_op     = SLL;
        kill      = 1'b0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_directed();
        test_backpressure();
        test_kill();
        test_rst_mid();
        test_back_to_back();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: %0d left required 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_serial_shifter
